// File: rtl/serial_capture_packer.sv
// Packs a ser_clk/ser_data bit stream into 32-bit AXI-stream words; the optional idle flush is built with SERCAP_IDLE_FLUSH_EN.
// Push one cycle after the 32nd rise, tvalid one cycle later; a push into a full FIFO is dropped and latched in o_overflow.
module serial_capture_packer #(
    parameter int FIFO_EA     = 4,
    parameter int PKT_WORDS   = 128,
    parameter int IDLE_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ser_clk,
    input  logic        ser_data,
    input  logic        o_tready,
    output logic        o_tvalid,
    output logic [31:0] o_tdata,
    output logic [3:0]  o_tkeep,
    output logic        o_tlast,
    output logic        o_overflow
);
    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] dat;
    } ent_t;

    localparam logic [FIFO_EA:0]   L_FULL = {1'b1, {FIFO_EA{1'b0}}};
    localparam logic [FIFO_EA-1:0] L_PONE = FIFO_EA'(1);

    if (PKT_WORDS < 1 || PKT_WORDS > 65535 || IDLE_CYCLES < 1 || IDLE_CYCLES > 24'hFFFFFF) begin : g_bad_param
        $error("serial_capture_packer: PKT_WORDS or IDLE_CYCLES out of range");
    end

    logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_prev;
    logic [1:0]        r_settle;
    logic [4:0]        r_bit_cnt;
    logic [31:0]       r_word;
    logic              r_stg_vld, r_stg_flush;
    logic [3:0]        r_stg_keep;
    logic [31:0]       r_stg_dat;
    logic [15:0]       r_word_cnt;
    logic              r_overflow;
    logic [FIFO_EA-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_EA:0]  r_count;
    ent_t              r_mem [(1<<FIFO_EA)];

    logic              w_rise, w_full, w_push, w_pop, w_stg_last;
    logic              w_flush, w_discard;
    logic [3:0]        w_fl_keep;
    logic [31:0]       w_fl_dat, w_word_nxt;
    ent_t              w_wr_ent, w_head;

    assign w_rise = r_clk_s2 & ~r_clk_prev;

    // Byte k of the word, MSB-first: bit_cnt = {k, i} lands on bit k*8 + (7-i).
    always_comb begin
        w_word_nxt = r_word;
        w_word_nxt[{r_bit_cnt[4:3], ~r_bit_cnt[2:0]}] = r_dat_s2;
    end

`ifdef SERCAP_IDLE_FLUSH_EN
    localparam logic [23:0] L_IDLE = 24'(IDLE_CYCLES);
    logic [23:0] r_idle;
    logic        w_idle_hit;

    assign w_idle_hit = (r_idle == L_IDLE) && !w_rise;
    assign w_discard  = w_idle_hit && (r_bit_cnt != 5'd0);
    assign w_flush    = w_idle_hit && (r_bit_cnt >= 5'd8);

    always_comb begin
        case (r_bit_cnt[4:3])
            2'd1:    w_fl_keep = 4'h1;
            2'd2:    w_fl_keep = 4'h3;
            default: w_fl_keep = 4'h7;
        endcase
        w_fl_dat = r_word & {{8{w_fl_keep[3]}}, {8{w_fl_keep[2]}}, {8{w_fl_keep[1]}}, {8{w_fl_keep[0]}}};
    end

    // Saturates at L_IDLE so only one flush can fire per idle period.
    always_ff @(posedge clk) begin
        if (!rstn)                r_idle <= '0;
        else if (w_rise)          r_idle <= '0;
        else if (r_idle != L_IDLE) r_idle <= r_idle + 24'd1;
    end
`else
    assign w_discard = 1'b0;
    assign w_flush   = 1'b0;
    assign w_fl_keep = 4'hF;
    assign w_fl_dat  = r_word;
`endif

    assign w_full     = (r_count == L_FULL);
    assign w_push     = r_stg_vld && !w_full;
    assign w_pop      = o_tvalid && o_tready;
    assign w_stg_last = r_stg_flush || (r_word_cnt == 16'(PKT_WORDS - 1));
    assign w_wr_ent   = '{last: w_stg_last, keep: r_stg_keep, dat: r_stg_dat};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_clk_s1    <= 1'b0;
            r_clk_s2    <= 1'b0;
            r_dat_s1    <= 1'b0;
            r_dat_s2    <= 1'b0;
            r_clk_prev  <= 1'b1;
            r_settle    <= 2'b00;
            r_bit_cnt   <= '0;
            r_word      <= '0;
            r_stg_vld   <= 1'b0;
            r_stg_flush <= 1'b0;
            r_stg_keep  <= '0;
            r_stg_dat   <= '0;
            r_word_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_clk_s1    <= ser_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= ser_data;
            r_dat_s2    <= r_dat_s1;
            // Hold prev high until the synchroniser has refilled, so a line already high at reset is not an edge.
            r_settle    <= {r_settle[0], 1'b1};
            r_clk_prev  <= r_settle[1] ? r_clk_s2 : 1'b1;
            r_stg_vld   <= 1'b0;
            r_stg_flush <= 1'b0;

            if (w_rise) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd31) begin
                    r_stg_vld  <= 1'b1;
                    r_stg_keep <= 4'hF;
                    r_stg_dat  <= w_word_nxt;
                    r_word     <= '0;
                end else begin
                    r_word <= w_word_nxt;
                end
            end else if (w_discard) begin
                r_bit_cnt <= '0;
                r_word    <= '0;
                if (w_flush) begin
                    r_stg_vld   <= 1'b1;
                    r_stg_flush <= 1'b1;
                    r_stg_keep  <= w_fl_keep;
                    r_stg_dat   <= w_fl_dat;
                end
            end

            if (r_stg_vld) begin
                if (w_full)          r_overflow <= 1'b1;
                else if (w_stg_last) r_word_cnt <= '0;
                else                 r_word_cnt <= r_word_cnt + 16'd1;
                if (r_stg_flush)     r_word_cnt <= '0;
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + L_PONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_ent;
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign o_tvalid   = (r_count != '0);
    assign o_tdata    = o_tvalid ? w_head.dat  : 32'h0;
    assign o_tkeep    = o_tvalid ? w_head.keep : 4'h0;
    assign o_tlast    = o_tvalid ? w_head.last : 1'b0;
    assign o_overflow = r_overflow;
endmodule

// File: tb/tb_serial_capture_packer.sv
// Randomised bench for serial_capture_packer with PKT_WORDS=4, FIFO_EA=2, IDLE_CYCLES=50.
module tb_serial_capture_packer;
    localparam int PKT = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ser_clk = 1'b0;
    logic        ser_data = 1'b0;
    logic        o_tready;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;
    logic        o_overflow;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_mode = 0;
    int          stall_err = 0;
    logic [36:0] rx [$];
    logic [36:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [36:0] prev_ent = '0;

    always #5 clk = ~clk;

    serial_capture_packer #(.FIFO_EA(2), .PKT_WORDS(PKT), .IDLE_CYCLES(50)) dut (
        .clk(clk), .rstn(rstn), .ser_clk(ser_clk), .ser_data(ser_data),
        .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
        .o_tkeep(o_tkeep), .o_tlast(o_tlast), .o_overflow(o_overflow)
    );

    // Ready is chosen first, so each sample below describes exactly the handshake at the next rising edge.
    always @(negedge clk) begin
        if (rdy_mode == 2) o_tready = 1'($urandom_range(0, 1));
        else               o_tready = (rdy_mode == 1);
        if (rstn && prev_stall && (!o_tvalid || {o_tlast, o_tkeep, o_tdata} !== prev_ent)) stall_err++;
        if (rstn && o_tvalid && o_tready) rx.push_back({o_tlast, o_tkeep, o_tdata});
        prev_stall = rstn && o_tvalid && !o_tready;
        prev_ent   = {o_tlast, o_tkeep, o_tdata};
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_data = b;
        clks(4);
        ser_clk = 1'b1;
        clks(4);
        ser_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clks(2);
        rx.delete();
        exp_q.delete();
        rstn = 1'b1;
        clks(3);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c;
        c = 0;
        while (rx.size() < n && c < budget) begin
            clks(1);
            c++;
        end
    endtask

    function automatic logic [36:0] rx_at(input int i);
        rx_at = (i < rx.size()) ? rx[i] : 37'bx;
    endfunction

    task automatic test_reset();
        ser_clk = 1'b1;
        rstn = 1'b0;
        clks(2);
        n_cmp++; if (o_tvalid !== 1'b0)    begin n_bad++; $display("FAIL reset_tvalid got %0b want 0", o_tvalid); end
        n_cmp++; if (o_tdata !== 32'h0)    begin n_bad++; $display("FAIL reset_tdata got %h want 0", o_tdata); end
        n_cmp++; if (o_tkeep !== 4'h0)     begin n_bad++; $display("FAIL reset_tkeep got %h want 0", o_tkeep); end
        n_cmp++; if (o_tlast !== 1'b0)     begin n_bad++; $display("FAIL reset_tlast got %0b want 0", o_tlast); end
        n_cmp++; if (o_overflow !== 1'b0)  begin n_bad++; $display("FAIL reset_overflow got %0b want 0", o_overflow); end
        rstn = 1'b1;
        clks(10);
        ser_clk = 1'b0;
        clks(4);
        n_cmp++; if (o_tvalid !== 1'b0)    begin n_bad++; $display("FAIL reset_idle_tvalid got %0b want 0", o_tvalid); end
    endtask

    task automatic test_ordering();
        rdy_mode = 1;
        do_reset();
        for (int b = 1; b <= 8; b++) send_byte(8'(b));
        wait_rx(2, 200);
        clks(20);
        exp_q.push_back({1'b0, 4'hF, 32'h04030201});
        exp_q.push_back({1'b0, 4'hF, 32'h08070605});
        n_cmp++; if (rx.size() !== 2) begin n_bad++; $display("FAIL ordering_count got %0d want 2", rx.size()); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (rx_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL ordering_word%0d got %h want %h", i, rx_at(i), exp_q[i]); end
        end
    endtask

    task automatic test_packet_boundary();
        logic [31:0] w;
        rdy_mode = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            exp_q.push_back({(i % PKT) == PKT - 1, 4'hF, w});
            send_word(w);
        end
        wait_rx(8, 200);
        clks(20);
        n_cmp++; if (rx.size() !== 8) begin n_bad++; $display("FAIL pkt_count got %0d want 8", rx.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rx_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL pkt_word%0d got %h want %h", i, rx_at(i), exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        rdy_mode = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            if (i < 4) exp_q.push_back({(i % PKT) == PKT - 1, 4'hF, w});
            send_word(w);
        end
        clks(10);
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %0b want 1", o_overflow); end
        n_cmp++; if (o_tvalid !== 1'b1)   begin n_bad++; $display("FAIL ovf_tvalid got %0b want 1", o_tvalid); end
        rdy_mode = 1;
        wait_rx(4, 100);
        clks(20);
        n_cmp++; if (rx.size() !== 4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", rx.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rx_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL ovf_word%0d got %h want %h", i, rx_at(i), exp_q[i]); end
        end
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", o_overflow); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int          bad;
        rdy_mode = 2;
        do_reset();
        stall_err = 0;
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            exp_q.push_back({(i % PKT) == PKT - 1, 4'hF, w});
            send_word(w);
        end
        wait_rx(100, 500);
        clks(20);
        n_cmp++; if (rx.size() !== 100) begin n_bad++; $display("FAIL bp_count got %0d want 100", rx.size()); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            n_cmp++;
            if (rx_at(i) !== exp_q[i]) begin
                n_bad++;
                if (bad < 5) $display("FAIL bp_word%0d got %h want %h", i, rx_at(i), exp_q[i]);
                bad++;
            end
        end
        n_cmp++; if (stall_err !== 0)     begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL bp_overflow got %0b want 0", o_overflow); end
    endtask

    task automatic test_idle();
        logic [31:0] w;
        rdy_mode = 1;
        do_reset();
        send_byte(8'hAB);
        send_byte(8'hCD);
`ifdef SERCAP_IDLE_FLUSH_EN
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        clks(120);
        n_cmp++; if (rx.size() !== 1) begin n_bad++; $display("FAIL idle_flush_count got %0d want 1", rx.size()); end
        n_cmp++;
        if (rx_at(0) !== {1'b1, 4'h3, 32'h0000CDAB}) begin n_bad++; $display("FAIL idle_flush_word got %h want %h", rx_at(0), {1'b1, 4'h3, 32'h0000CDAB}); end
        w = $urandom;
        send_word(w);
        wait_rx(2, 100);
        clks(20);
        n_cmp++; if (rx.size() !== 2) begin n_bad++; $display("FAIL idle_next_count got %0d want 2", rx.size()); end
        n_cmp++;
        if (rx_at(1) !== {1'b0, 4'hF, w}) begin n_bad++; $display("FAIL idle_next_word got %h want %h", rx_at(1), {1'b0, 4'hF, w}); end
`else
        clks(200);
        n_cmp++; if (rx.size() !== 0) begin n_bad++; $display("FAIL idle_hold_count got %0d want 0", rx.size()); end
        send_byte(8'hEF);
        send_byte(8'h12);
        wait_rx(1, 100);
        clks(20);
        n_cmp++; if (rx.size() !== 1) begin n_bad++; $display("FAIL idle_resume_count got %0d want 1", rx.size()); end
        n_cmp++;
        if (rx_at(0) !== {1'b0, 4'hF, 32'h12EFCDAB}) begin n_bad++; $display("FAIL idle_resume_word got %h want %h", rx_at(0), {1'b0, 4'hF, 32'h12EFCDAB}); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        rdy_mode = 1;
        do_reset();
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        ser_clk = 1'b1;
        clks(6);
        rstn = 1'b0;
        clks(1);
        rstn = 1'b1;
        clks(10);
        ser_clk = 1'b0;
        clks(4);
        w = $urandom;
        send_word(w);
        wait_rx(1, 100);
        clks(30);
        n_cmp++; if (rx.size() !== 1) begin n_bad++; $display("FAIL rstmid_count got %0d want 1", rx.size()); end
        n_cmp++;
        if (rx_at(0) !== {1'b0, 4'hF, w}) begin n_bad++; $display("FAIL rstmid_word got %h want %h", rx_at(0), {1'b0, 4'hF, w}); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_packet_boundary();
        test_overflow();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
